// File: rtl/ddr5_deser_seq_ctrl_if.sv
// Request/status bundle between the read-timing logic and the deserializer sequencer.
// The sequencer side (slave) drives the deserializer controls and status.
interface ddr5_deser_seq_ctrl_if #(
  parameter int unsigned BL_W  = 5,
  parameter int unsigned LAT_W = 4
);
  logic             start_i;
  logic [BL_W-1:0]  burst_len_i;
  logic [LAT_W-1:0] lat_i;
  logic             abort_i;
  logic             ready_o;
  logic             busy_o;
  logic             enable_o;
  logic [1:0]       phase_sel_o;
  logic             count_done_o;
  logic             word_valid_o;
  logic             done_o;
  logic             err_o;

  modport master (
    output start_i, burst_len_i, lat_i, abort_i,
    input  ready_o, busy_o, enable_o, phase_sel_o, count_done_o,
           word_valid_o, done_o, err_o
  );

  modport slave (
    input  start_i, burst_len_i, lat_i, abort_i,
    output ready_o, busy_o, enable_o, phase_sel_o, count_done_o,
           word_valid_o, done_o, err_o
  );
endinterface

// File: rtl/ddr5_deser_seq_ctrl.sv
// Read-burst sequencer for the DDR5 deserializer: waits the programmed latency,
// steps the phase select beat by beat and flags each completed 4-beat word.
module ddr5_deser_seq_ctrl #(
  parameter int unsigned MAX_BL = 16,
  parameter int unsigned BL_W   = 5,
  parameter int unsigned LAT_W  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  ddr5_deser_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t           state_q, state_n;
  logic [BL_W-1:0]  len_q, len_n;
  logic [BL_W-1:0]  beat_q, beat_n;
  logic [LAT_W-1:0] wait_q, wait_n;
  logic             v1_q, wv_q, err_q;
  logic             err_n;

  logic             ready_c;
  logic             abort_c;
  logic             legal_c;
  logic             accept_c;
  logic             enable_c;
  logic             count_done_c;

  assign ready_c  = (state_q == S_IDLE) || (state_q == S_DRAIN);
  assign abort_c  = bus.abort_i && (state_q != S_IDLE);
  assign legal_c  = (bus.burst_len_i != '0) && (bus.burst_len_i[1:0] == 2'b00) &&
                    (bus.burst_len_i <= BL_W'(MAX_BL));
  assign accept_c = bus.start_i && ready_c && !abort_c && legal_c;

  // Deserializer controls decoded from registered state and beat counter
  assign enable_c     = (state_q == S_CAPTURE) || (state_q == S_DRAIN);
  assign count_done_c = (state_q == S_CAPTURE) && (beat_q[1:0] == 2'b11);

  assign bus.ready_o      = ready_c;
  assign bus.busy_o       = (state_q != S_IDLE);
  assign bus.enable_o     = enable_c;
  assign bus.phase_sel_o  = (state_q == S_CAPTURE) ? beat_q[1:0] : 2'b00;
  assign bus.count_done_o = count_done_c;
  assign bus.done_o       = (state_q == S_DRAIN);
  assign bus.word_valid_o = wv_q;
  assign bus.err_o        = err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      v1_q    <= 1'b0;
      wv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      len_q   <= len_n;
      beat_q  <= beat_n;
      wait_q  <= wait_n;
      v1_q    <= enable_c && count_done_c;
      // Gating by enable drops a pending word when the burst is aborted
      wv_q    <= v1_q && enable_c;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    len_n   = len_q;
    beat_n  = beat_q;
    wait_n  = wait_q;
    err_n   = bus.start_i && ready_c && !abort_c && !legal_c;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          len_n   = bus.burst_len_i;
          wait_n  = bus.lat_i;
          beat_n  = '0;
          state_n = (bus.lat_i != '0) ? S_WAIT : S_CAPTURE;
        end
      end
      S_WAIT: begin
        wait_n = wait_q - LAT_W'(1);
        if (wait_q == LAT_W'(1)) state_n = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (beat_q == len_q - BL_W'(1)) begin
          beat_n  = '0;
          state_n = S_DRAIN;
        end else begin
          beat_n = beat_q + BL_W'(1);
        end
      end
      S_DRAIN: begin
        state_n = S_IDLE;
        if (accept_c) begin
          len_n   = bus.burst_len_i;
          wait_n  = bus.lat_i;
          beat_n  = '0;
          state_n = (bus.lat_i != '0) ? S_WAIT : S_CAPTURE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (abort_c) begin
      state_n = S_IDLE;
      len_n   = '0;
      beat_n  = '0;
      wait_n  = '0;
    end
  end

endmodule

// File: tb/tb_ddr5_deser_seq_ctrl.sv
// Directed bench for ddr5_deser_seq_ctrl: cycle-by-cycle expected output vectors
// per scenario, derived by hand from the burst timing rules.
module tb_ddr5_deser_seq_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   errors = 0;
  int   checks = 0;

  ddr5_deser_seq_ctrl_if #(.BL_W(5), .LAT_W(4)) bus ();

  ddr5_deser_seq_ctrl #(.MAX_BL(16), .BL_W(5), .LAT_W(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  // {enable, phase_sel, count_done, word_valid, done, err, busy, ready}
  function automatic logic [8:0] obs();
    return {bus.enable_o, bus.phase_sel_o, bus.count_done_o, bus.word_valid_o,
            bus.done_o, bus.err_o, bus.busy_o, bus.ready_o};
  endfunction

  function automatic logic [8:0] pack(input logic en, input logic [1:0] ph, input logic cd,
                                      input logic wv, input logic dn, input logic er,
                                      input logic bz, input logic rd);
    return {en, ph, cd, wv, dn, er, bz, rd};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_burst(input logic [4:0] len, input logic [3:0] lat);
    bus.start_i     = 1'b1;
    bus.burst_len_i = len;
    bus.lat_i       = lat;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    exp = pack(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL reset got=%b exp=%b", obs(), exp);
    end
  endtask

  // len=8, lat=0: beats T1..T8, drain T9, words visible T6 and T10
  task automatic test_len8_lat0();
    logic [8:0] exp;
    start_burst(5'd8, 4'd0);
    tick();
    bus.start_i = 1'b0;
    for (int t = 1; t <= 11; t++) begin
      exp = pack(t <= 9, (t <= 8) ? 2'((t - 1) % 4) : 2'd0, t == 4 || t == 8,
                 t == 6 || t == 10, t == 9, 1'b0, t <= 9, t >= 9);
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL len8_lat0 t=%0d got=%b exp=%b", t, obs(), exp);
      end
      tick();
    end
  endtask

  // len=4, lat=3: wait T1..T3, beats T4..T7, drain T8, word T9
  task automatic test_latency();
    logic [8:0] exp;
    start_burst(5'd4, 4'd3);
    tick();
    bus.start_i = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      exp = pack(t >= 4 && t <= 8, (t >= 4 && t <= 7) ? 2'(t - 4) : 2'd0, t == 7,
                 t == 9, t == 8, 1'b0, t <= 8, t >= 8);
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL latency t=%0d got=%b exp=%b", t, obs(), exp);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [4:0] lens [3];
    logic [8:0] exp;
    lens[0] = 5'd6;
    lens[1] = 5'd0;
    lens[2] = 5'd20;
    for (int i = 0; i < 3; i++) begin
      start_burst(lens[i], 4'd2);
      tick();
      bus.start_i = 1'b0;
      exp = pack(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL illegal_err len=%0d got=%b exp=%b", lens[i], obs(), exp);
      end
      tick();
      exp = pack(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL illegal_after len=%0d got=%b exp=%b", lens[i], obs(), exp);
      end
    end
  endtask

  // Abort during beat 4 (T5): idle from T6, only the first word survives
  task automatic test_abort();
    logic [8:0] exp;
    start_burst(5'd8, 4'd0);
    tick();
    bus.start_i = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      exp = pack(t <= 5, (t <= 5) ? 2'((t - 1) % 4) : 2'd0, t == 4,
                 t == 6, 1'b0, 1'b0, t <= 5, t >= 6);
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL abort t=%0d got=%b exp=%b", t, obs(), exp);
      end
      bus.abort_i = (t == 5);
      tick();
    end
    bus.abort_i = 1'b0;
  endtask

  // Abort while waiting the latency: must return idle without any beat
  task automatic test_abort_wait();
    logic [8:0] exp;
    start_burst(5'd4, 4'd5);
    tick();
    bus.start_i = 1'b0;
    tick();
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    for (int t = 3; t <= 9; t++) begin
      exp = pack(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL abort_wait t=%0d got=%b exp=%b", t, obs(), exp);
      end
      tick();
    end
  endtask

  // Second len=4 request accepted in drain (T5): beats T6..T9, drain T10
  task automatic test_back_to_back();
    logic [8:0] exp;
    logic       cap;
    start_burst(5'd4, 4'd0);
    tick();
    bus.start_i = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      cap = (t >= 1 && t <= 4) || (t >= 6 && t <= 9);
      exp = pack(t <= 10, cap ? 2'((t <= 4) ? t - 1 : t - 6) : 2'd0, t == 4 || t == 9,
                 t == 6 || t == 11, t == 5 || t == 10, 1'b0, t <= 10, !cap);
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL back_to_back t=%0d got=%b exp=%b", t, obs(), exp);
      end
      if (t == 5) start_burst(5'd4, 4'd0);
      else bus.start_i = 1'b0;
      tick();
    end
  endtask

  // Async reset mid-capture, then a len=4 lat=1 burst must run normally
  task automatic test_reset_midburst();
    logic [8:0] exp;
    start_burst(5'd8, 4'd0);
    tick();
    bus.start_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    exp = pack(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL reset_async got=%b exp=%b", obs(), exp);
    end
    tick();
    rst_i = 1'b1;
    tick();
    start_burst(5'd4, 4'd1);
    tick();
    bus.start_i = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      exp = pack(t >= 2 && t <= 6, (t >= 2 && t <= 5) ? 2'(t - 2) : 2'd0, t == 5,
                 t == 7, t == 6, 1'b0, t <= 6, t >= 6);
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL restart t=%0d got=%b exp=%b", t, obs(), exp);
      end
      tick();
    end
  endtask

  initial begin
    bus.start_i     = 1'b0;
    bus.burst_len_i = '0;
    bus.lat_i       = '0;
    bus.abort_i     = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    test_reset();
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    test_reset();
    test_len8_lat0();
    test_latency();
    test_illegal();
    test_abort();
    test_abort_wait();
    test_back_to_back();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
